// File: rtl/drsstc_pkg.sv
// Shared types and helpers for the bridge
// gate-timing stage.
package drsstc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEAD,
    ON_A,
    ON_B,
    FAULT
  } bd_state_t;

  typedef enum logic [1:0] {
    NONE,
    A,
    B,
    ILLEGAL
  } bd_req_t;

  // ceil(ns * clk_mhz / 1000), never below 1
  function automatic int ns2cyc(
    input int ns,
    input int clk_mhz
  );
    int c;
    c = (ns * clk_mhz + 999) / 1000;
    if (c < 1) c = 1;
    return c;
  endfunction

  function automatic int max2(
    input int a,
    input int b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bd_timer.sv
// Loadable down-counter with zero flag.
// Ports: clk, rst, load, load_val, dec -> zero.
module bd_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Saturates at zero; load wins over decrement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/bridge_dead_time.sv
// Full-bridge gate timing: dead time, min on-time, fault latch.
// Ports: clk, rst, in_p, in_n, flt_clr -> gate_a, gate_b, fault.
module bridge_dead_time
  import drsstc_pkg::*;
#(
  parameter int CLK_MHZ   = 100,
  parameter int DEAD_NS   = 200,
  parameter int MIN_ON_NS = 500
) (
  input  logic clk,
  input  logic rst,
  input  logic in_p,
  input  logic in_n,
  input  logic flt_clr,
  output logic gate_a,
  output logic gate_b,
  output logic fault
);

  localparam int DEAD_CYC   = ns2cyc(DEAD_NS, CLK_MHZ);
  localparam int MIN_ON_CYC = ns2cyc(MIN_ON_NS, CLK_MHZ);
  localparam int CW =
    $clog2(max2(DEAD_CYC, MIN_ON_CYC) + 1);

  localparam logic [CW-1:0] DEAD_LD = CW'(DEAD_CYC - 1);
  localparam logic [CW-1:0] MIN_LD  = CW'(MIN_ON_CYC - 1);

  bd_state_t      state;
  bd_state_t      nxt;
  bd_req_t        req;
  bd_req_t        tgt;
  bd_req_t        nxt_tgt;
  bd_req_t        own;
  logic           ld;
  logic           dec;
  logic [CW-1:0]  ld_val;
  logic           zero;

  bd_timer #(
    .W(CW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (ld),
    .load_val (ld_val),
    .dec      (dec),
    .zero     (zero)
  );

  always_comb begin
    req = NONE;
    unique case ({in_p, in_n})
      2'b10:   req = A;
      2'b01:   req = B;
      2'b11:   req = ILLEGAL;
      default: req = NONE;
    endcase
  end

  always_comb begin
    nxt     = state;
    nxt_tgt = tgt;
    ld      = 1'b0;
    ld_val  = DEAD_LD;
    dec     = 1'b0;
    own     = (state == ON_A) ? A : B;
    if (state != FAULT && req == ILLEGAL) begin
      nxt = FAULT;
    end else begin
      unique case (state)
        IDLE: begin
          if (req != NONE) begin
            nxt     = DEAD;
            nxt_tgt = req;
            ld      = 1'b1;
          end
        end
        DEAD: begin
          if (req == NONE) begin
            nxt = IDLE;
          end else if (req != tgt) begin
            // retarget restarts the full dead time
            nxt_tgt = req;
            ld      = 1'b1;
          end else if (zero) begin
            nxt    = (tgt == A) ? ON_A : ON_B;
            ld     = 1'b1;
            ld_val = MIN_LD;
          end else begin
            dec = 1'b1;
          end
        end
        ON_A, ON_B: begin
          // min-on hold: ignore release until zero
          if (!zero) begin
            dec = 1'b1;
          end else if (req != own) begin
            if (req == NONE) begin
              nxt = IDLE;
            end else begin
              nxt     = DEAD;
              nxt_tgt = req;
              ld      = 1'b1;
            end
          end
        end
        FAULT: begin
          if (flt_clr && req == NONE) nxt = IDLE;
        end
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      tgt    <= A;
      gate_a <= 1'b0;
      gate_b <= 1'b0;
      fault  <= 1'b0;
    end else begin
      state  <= nxt;
      tgt    <= nxt_tgt;
      gate_a <= (nxt == ON_A);
      gate_b <= (nxt == ON_B);
      fault  <= (nxt == FAULT);
    end
  end

endmodule
